// File: rtl/taxi_clk_rst_seq.sv
// ============================================================================
// taxi_clk_rst_seq : MMCM / Ethernet PHY / core reset sequencer with lock
//                    supervision, bounded lock retries and a latched FAIL state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module taxi_clk_rst_seq #(
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int PHY_RST_CYCLES      = 1000000,
  parameter int PHY_SETTLE_CYCLES   = 5000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mmcm_locked,
  input  logic       restart,
  output logic       mmcm_rst,
  output logic       phy_reset_n,
  output logic       core_rst,
  output logic       ready,
  output logic       lock_fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_MAX_CYC = max2(max2(max2(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                       max2(LOCK_STABLE_CYCLES, PHY_RST_CYCLES)),
                                  PHY_SETTLE_CYCLES);
  localparam int c_CNT_W = $clog2(c_MAX_CYC + 1);
  localparam int c_TO_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [c_CNT_W-1:0] c_MMCM_LAST   = c_CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST     = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_PHY_LAST    = c_CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(PHY_SETTLE_CYCLES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LIMIT    = c_TO_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_MMCM_RST    = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_PHY_RST     = 3'd3,
    S_PHY_SETTLE  = 3'd4,
    S_RUN         = 3'd5,
    S_FAIL        = 3'd6
  } state_t;

  logic               r_lock_meta;
  logic               r_lock_sync;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TO_W-1:0]  r_to;
  logic [3:0]         r_retry;
  logic               r_mmcm_rst;
  logic               r_phy_reset_n;
  logic               r_core_rst;
  logic               r_ready;
  logic               r_lock_fail;

  state_t             w_nxt_state;
  logic [c_CNT_W-1:0] w_nxt_cnt;
  logic [c_TO_W-1:0]  w_nxt_to;
  logic [3:0]         w_nxt_retry;
  logic [c_TO_W-1:0]  w_to_inc;
  logic [3:0]         w_retry_inc;

  assign w_to_inc    = r_to + c_TO_W'(1);
  assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

  // Priority: restart, then lock loss, then phase-counter expiry.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_to    = r_to;
    w_nxt_retry = r_retry;
    if (restart) begin
      w_nxt_state = S_MMCM_RST;
      w_nxt_to    = '0;
      w_nxt_retry = '0;
    end else begin
      case (r_state)
        S_MMCM_RST: begin
          if (r_cnt == c_MMCM_LAST) w_nxt_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (r_lock_sync) begin
            w_nxt_state = S_LOCK_STABLE;
          end else if (r_cnt == c_TO_LAST) begin
            w_nxt_to    = w_to_inc;
            w_nxt_retry = w_retry_inc;
            w_nxt_state = (w_to_inc == c_TO_LIMIT) ? S_FAIL : S_MMCM_RST;
          end
        end
        S_LOCK_STABLE: begin
          if (!r_lock_sync) begin
            w_nxt_state = S_MMCM_RST;
            w_nxt_retry = w_retry_inc;
          end else if (r_cnt == c_STABLE_LAST) begin
            w_nxt_state = S_PHY_RST;
          end
        end
        S_PHY_RST: begin
          if (!r_lock_sync) begin
            w_nxt_state = S_MMCM_RST;
            w_nxt_retry = w_retry_inc;
          end else if (r_cnt == c_PHY_LAST) begin
            w_nxt_state = S_PHY_SETTLE;
          end
        end
        S_PHY_SETTLE: begin
          if (!r_lock_sync) begin
            w_nxt_state = S_MMCM_RST;
            w_nxt_retry = w_retry_inc;
          end else if (r_cnt == c_SETTLE_LAST) begin
            w_nxt_state = S_RUN;
            w_nxt_to    = '0;
          end
        end
        S_RUN: begin
          if (!r_lock_sync) begin
            w_nxt_state = S_MMCM_RST;
            w_nxt_retry = w_retry_inc;
          end
        end
        S_FAIL: begin
          w_nxt_state = S_FAIL;
        end
        default: begin
          w_nxt_state = S_MMCM_RST;
        end
      endcase
    end

    // RUN and FAIL are untimed, so the counter is frozen there.
    if (restart || (w_nxt_state != r_state))
      w_nxt_cnt = '0;
    else if ((r_state == S_RUN) || (r_state == S_FAIL))
      w_nxt_cnt = r_cnt;
    else
      w_nxt_cnt = r_cnt + c_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta   <= 1'b0;
      r_lock_sync   <= 1'b0;
      r_state       <= S_MMCM_RST;
      r_cnt         <= '0;
      r_to          <= '0;
      r_retry       <= '0;
      r_mmcm_rst    <= 1'b1;
      r_phy_reset_n <= 1'b0;
      r_core_rst    <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_fail   <= 1'b0;
    end else begin
      r_lock_meta   <= mmcm_locked;
      r_lock_sync   <= r_lock_meta;
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_to          <= w_nxt_to;
      r_retry       <= w_nxt_retry;
      r_mmcm_rst    <= (w_nxt_state == S_MMCM_RST) || (w_nxt_state == S_FAIL);
      r_phy_reset_n <= (w_nxt_state == S_PHY_SETTLE) || (w_nxt_state == S_RUN);
      r_core_rst    <= (w_nxt_state != S_RUN);
      r_ready       <= (w_nxt_state == S_RUN);
      r_lock_fail   <= (w_nxt_state == S_FAIL);
    end
  end

  assign mmcm_rst    = r_mmcm_rst;
  assign phy_reset_n = r_phy_reset_n;
  assign core_rst    = r_core_rst;
  assign ready       = r_ready;
  assign lock_fail   = r_lock_fail;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_taxi_clk_rst_seq.sv
// ============================================================================
// tb_taxi_clk_rst_seq : directed + randomized bench for taxi_clk_rst_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_taxi_clk_rst_seq;

  localparam int P_MMCM   = 4;
  localparam int P_TO     = 20;
  localparam int P_STABLE = 8;
  localparam int P_PHY    = 10;
  localparam int P_SETTLE = 5;
  localparam int P_MAX    = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       mmcm_locked = 1'b1;
  logic       restart = 1'b0;
  logic       mmcm_rst;
  logic       phy_reset_n;
  logic       core_rst;
  logic       ready;
  logic       lock_fail;
  logic [3:0] retry_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  taxi_clk_rst_seq #(
    .MMCM_RST_CYCLES    (P_MMCM),
    .LOCK_TIMEOUT_CYCLES(P_TO),
    .LOCK_STABLE_CYCLES (P_STABLE),
    .PHY_RST_CYCLES     (P_PHY),
    .PHY_SETTLE_CYCLES  (P_SETTLE),
    .MAX_RETRIES        (P_MAX)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mmcm_locked(mmcm_locked),
    .restart    (restart),
    .mmcm_rst   (mmcm_rst),
    .phy_reset_n(phy_reset_n),
    .core_rst   (core_rst),
    .ready      (ready),
    .lock_fail  (lock_fail),
    .retry_count(retry_count),
    .state      (state)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase number, cycles spent in it, and a delay line for lock.
  int m_phase, m_elapsed, m_timeouts, m_retries;
  bit m_s1, m_s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      0: return P_MMCM;
      1: return P_TO;
      2: return P_STABLE;
      3: return P_PHY;
      4: return P_SETTLE;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_timeouts = 0; m_retries = 0;
    m_s1 = 0; m_s2 = 0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_elapsed = 0;
  endtask

  task automatic bump();
    if (m_retries < 15) m_retries++;
  endtask

  task automatic model_step();
    bit lk;
    lk = m_s2;
    m_s2 = m_s1;
    m_s1 = mmcm_locked;
    if (restart) begin
      m_phase = 0; m_elapsed = 0; m_timeouts = 0; m_retries = 0;
      return;
    end
    m_elapsed++;
    case (m_phase)
      0: if (m_elapsed == P_MMCM) enter(1);
      1: begin
        if (lk) enter(2);
        else if (m_elapsed == P_TO) begin
          m_timeouts++;
          bump();
          enter((m_timeouts == P_MAX) ? 6 : 0);
        end
      end
      2, 3, 4: begin
        if (!lk) begin
          bump();
          enter(0);
        end else if (m_elapsed == dur(m_phase)) begin
          if (m_phase == 4) m_timeouts = 0;
          enter(m_phase + 1);
        end
      end
      5: if (!lk) begin bump(); enter(0); end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check("state", state, m_phase);
    check("mmcm_rst", mmcm_rst, (m_phase == 0) || (m_phase == 6));
    check("phy_reset_n", phy_reset_n, (m_phase == 4) || (m_phase == 5));
    check("core_rst", core_rst, m_phase != 5);
    check("ready", ready, m_phase == 5);
    check("lock_fail", lock_fail, m_phase == 6);
    check("retry_count", retry_count, m_retries);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic wait_phase(input int p, input int budget);
    for (int i = 0; i < budget && m_phase != p; i++) cycle();
    check($sformatf("reach_phase%0d", p), m_phase, p);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_mmcm_rst"}, mmcm_rst, 1);
    check({tag, "_phy_reset_n"}, phy_reset_n, 0);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_lock_fail"}, lock_fail, 0);
    check({tag, "_retry"}, retry_count, 0);
  endtask

  initial begin
    int phy_rise, core_fall, n, low_left;
    logic prev_phy, prev_core;

    model_reset();
    #1 reset_n = 1'b0;
    #2 check_reset_vals("por");
    cycle();
    cycle();
    reset_n = 1'b1;

    // Bring-up with lock held high
    phy_rise = 0; core_fall = 0; prev_phy = 1'b0; prev_core = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      cycle();
      if (c == 3) check("mmcm_rst_c3", mmcm_rst, 1);
      if (c == 4) check("mmcm_rst_c4", mmcm_rst, 0);
      if (!prev_phy && phy_reset_n && phy_rise == 0) phy_rise = c;
      if (prev_core && !core_rst && core_fall == 0) core_fall = c;
      prev_phy = phy_reset_n;
      prev_core = core_rst;
    end
    check("phy_rise_cycle", phy_rise, 23);
    check("core_fall_cycle", core_fall, 28);
    check("bringup_ready", ready, 1);
    check("bringup_retry", retry_count, 0);

    // Lock lost for 3 cycles in RUN
    mmcm_locked = 1'b0;
    cycle(); cycle(); cycle();
    check("loss_core_rst", core_rst, 1);
    check("loss_phy_reset_n", phy_reset_n, 0);
    check("loss_state", state, 0);
    check("loss_retry", retry_count, 1);
    mmcm_locked = 1'b1;
    wait_phase(5, 60);
    check("relock_ready", ready, 1);

    // One-cycle glitch in RUN, then one-cycle glitch in LOCK_STABLE
    mmcm_locked = 1'b0; cycle(); mmcm_locked = 1'b1;
    wait_phase(2, 60);
    cycle(); cycle(); cycle();
    mmcm_locked = 1'b0; cycle(); mmcm_locked = 1'b1;
    wait_phase(0, 10);
    wait_phase(2, 60);
    n = 0;
    while (state == 3'd2 && n < 30) begin cycle(); n++; end
    check("stable_len", n, P_STABLE);
    check("glitch_retry", retry_count, 3);

    // restart coinciding with lock loss in RUN
    wait_phase(5, 60);
    mmcm_locked = 1'b0;
    cycle(); cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    mmcm_locked = 1'b1;
    check("rst_loss_state", state, 0);
    check("rst_loss_retry", retry_count, 0);

    // Twenty lock-loss restarts saturate retry_count
    for (int k = 0; k < 20; k++) begin
      wait_phase(2, 60);
      mmcm_locked = 1'b0; cycle(); mmcm_locked = 1'b1;
      wait_phase(0, 10);
    end
    check("retry_saturate", retry_count, 15);

    // Lock never arrives: timeouts lead to FAIL
    restart = 1'b1; cycle(); restart = 1'b0;
    mmcm_locked = 1'b0;
    wait_phase(6, 80);
    check("fail_state", state, 6);
    check("fail_lock_fail", lock_fail, 1);
    check("fail_mmcm_rst", mmcm_rst, 1);
    check("fail_retry", retry_count, 2);
    mmcm_locked = 1'b1;
    repeat (10) cycle();
    check("fail_sticky", state, 6);
    restart = 1'b1; cycle(); restart = 1'b0;
    check("fail_exit_state", state, 0);
    check("fail_exit_retry", retry_count, 0);
    check("fail_exit_lock_fail", lock_fail, 0);

    // Randomized lock dropouts and occasional restarts
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        mmcm_locked = 1'b0;
        low_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        low_left = int'($urandom_range(1, 50));
        mmcm_locked = 1'b0;
      end else begin
        mmcm_locked = 1'b1;
      end
      restart = ($urandom_range(0, 199) == 0);
      cycle();
    end
    restart = 1'b0;
    mmcm_locked = 1'b1;

    // Asynchronous reset during PHY_SETTLE
    restart = 1'b1; cycle(); restart = 1'b0;
    wait_phase(2, 60);
    mmcm_locked = 1'b0; cycle(); mmcm_locked = 1'b1;
    wait_phase(4, 100);
    cycle();
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async");
    model_reset();
    cycle(); cycle();
    reset_n = 1'b1;
    wait_phase(5, 60);
    check("post_reset_ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
